// File: rtl/dsram_store_sched.sv
// Data-SRAM port scheduler: loads take the single port with priority, stores are
// buffered in a small in-order queue and drained on free cycles.
module dsram_store_sched #(
   parameter int SQ_DEPTH        = 4,
   parameter int MAX_LOAD_STREAK = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_es_req_valid,
   input  logic                       i_es_req_wr,
   input  logic [3:0]                 i_es_req_wstrb,
   input  logic [31:0]                i_es_req_addr,
   input  logic [31:0]                i_es_req_wdata,
   output logic                       o_es_req_ready,
   output logic                       o_data_sram_en,
   output logic [3:0]                 o_data_sram_wen,
   output logic [31:0]                o_data_sram_addr,
   output logic [31:0]                o_data_sram_wdata,
   output logic [$clog2(SQ_DEPTH):0]  o_sq_count,
   output logic                       o_sq_empty
);

   localparam int PW = $clog2(SQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(MAX_LOAD_STREAK + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(SQ_DEPTH);
   localparam logic [SW-1:0] STREAK_C = SW'(MAX_LOAD_STREAK);

   logic [31:0]   r_addr  [SQ_DEPTH];
   logic [3:0]    r_wstrb [SQ_DEPTH];
   logic [31:0]   r_wdata [SQ_DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_streak;

   logic w_empty;
   logic w_hit;
   logic w_force_drain;
   logic w_ld_go;
   logic w_st_go;
   logic w_push;
   logic w_drain;

   // Conservative word-granular match against every live entry; strobes are ignored.
   always_comb begin
      logic [PW-1:0] v_ofs;
      w_hit = 1'b0;
      v_ofs = '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         v_ofs = PW'(i) - r_head;
         if ((CW'(v_ofs) < r_count) && (r_addr[i][31:2] == i_es_req_addr[31:2]))
            w_hit = 1'b1;
      end
      w_hit = w_hit & i_es_req_valid & ~i_es_req_wr;
   end

   assign w_empty       = (r_count == '0);
   assign w_force_drain = ~w_empty & (r_streak == STREAK_C);
   assign w_ld_go       = i_es_req_valid & ~i_es_req_wr & ~w_hit & ~w_force_drain & ~i_reset;
   assign w_st_go       = i_es_req_valid & i_es_req_wr & (r_count < DEPTH_C) & ~i_reset;
   // Zero-strobe stores are acknowledged but never occupy a slot.
   assign w_push        = w_st_go & (i_es_req_wstrb != 4'h0);
   assign w_drain       = ~w_empty & ~w_ld_go & ~i_reset;

   assign o_es_req_ready = w_ld_go | w_st_go;
   assign o_sq_count     = r_count;
   assign o_sq_empty     = w_empty;

   always_comb begin
      o_data_sram_en    = 1'b0;
      o_data_sram_wen   = 4'h0;
      o_data_sram_addr  = 32'h0;
      o_data_sram_wdata = 32'h0;
      if (w_ld_go) begin
         o_data_sram_en   = 1'b1;
         o_data_sram_addr = i_es_req_addr;
      end else if (w_drain) begin
         o_data_sram_en    = 1'b1;
         o_data_sram_wen   = r_wstrb[r_head];
         o_data_sram_addr  = r_addr[r_head];
         o_data_sram_wdata = r_wdata[r_head];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_addr[r_tail]  <= i_es_req_addr;
         r_wstrb[r_tail] <= i_es_req_wstrb;
         r_wdata[r_tail] <= i_es_req_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_streak <= '0;
      end else begin
         if (w_push)
            r_tail <= r_tail + PW'(1);
         if (w_drain)
            r_head <= r_head + PW'(1);
         case ({w_push, w_drain})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // Streak only counts loads that overtook a non-empty queue.
         if (w_empty || w_drain)
            r_streak <= '0;
         else if (w_ld_go && (r_streak != STREAK_C))
            r_streak <= r_streak + SW'(1);
      end
   end

endmodule

// File: tb/tb_dsram_store_sched.sv
// Bench for dsram_store_sched: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_dsram_store_sched;

   localparam int D   = 4;
   localparam int MAX = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, wr;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   logic        ready, en, empty;
   logic [3:0]  wen;
   logic [31:0] s_addr, s_wdata;
   logic [$clog2(D):0] count;

   int checks = 0;
   int errors = 0;

   dsram_store_sched #(.SQ_DEPTH(D), .MAX_LOAD_STREAK(MAX)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_es_req_valid(valid), .i_es_req_wr(wr), .i_es_req_wstrb(wstrb),
      .i_es_req_addr(addr), .i_es_req_wdata(wdata),
      .o_es_req_ready(ready), .o_data_sram_en(en), .o_data_sram_wen(wen),
      .o_data_sram_addr(s_addr), .o_data_sram_wdata(s_wdata),
      .o_sq_count(count), .o_sq_empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
   } ent_t;

   ent_t q[$];
   int   streak = 0;
   bit   synced = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_eval(output bit ld, output bit st, output bit dr);
      bit hit = 0;
      foreach (q[k]) if (q[k].a[31:2] == addr[31:2]) hit = 1;
      hit = hit && valid && !wr;
      ld = valid && !wr && !hit && !(q.size() != 0 && streak == MAX) && !rst;
      st = valid && wr && (q.size() < D) && !rst;
      dr = (q.size() != 0) && !ld && !rst;
   endfunction

   // Reference model state advance.
   always @(posedge clk) begin
      bit ld, st, dr, was_empty;
      model_eval(ld, st, dr);
      was_empty = (q.size() == 0);
      if (rst) begin
         q.delete();
         streak = 0;
         synced = 1;
      end else begin
         if (dr) void'(q.pop_front());
         if (st && wstrb != 4'h0) q.push_back('{a: addr, s: wstrb, d: wdata});
         if (was_empty || dr) streak = 0;
         else if (ld && streak < MAX) streak++;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      bit ld, st, dr;
      logic [3:0]  e_wen;
      logic [31:0] e_addr, e_wdata;
      logic        e_en;
      if (synced) begin
         model_eval(ld, st, dr);
         e_en = 0; e_wen = 0; e_addr = 0; e_wdata = 0;
         if (ld) begin
            e_en = 1; e_addr = addr;
         end else if (dr) begin
            e_en = 1; e_wen = q[0].s; e_addr = q[0].a; e_wdata = q[0].d;
         end
         chk("m_ready", 32'(ready), 32'(ld || st));
         chk("m_en", 32'(en), 32'(e_en));
         chk("m_wen", 32'(wen), 32'(e_wen));
         chk("m_addr", s_addr, e_addr);
         chk("m_wdata", s_wdata, e_wdata);
         chk("m_count", 32'(count), 32'(q.size()));
         chk("m_empty", 32'(empty), 32'(q.size() == 0));
      end
   end

   task automatic set_in(input logic v, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      valid = v; wr = w; wstrb = s; addr = a; wdata = d;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; valid = 0; wr = 0; wstrb = 0; addr = 0; wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_en", 32'(en), 0);
      @(posedge clk); #1; rst = 0;
      @(negedge clk);
      chk("post_rst_count", 32'(count), 0);
      chk("post_rst_empty", 32'(empty), 1);
      chk("post_rst_addr", s_addr, 0);

      // Single store drains on the next free cycle.
      set_in(1, 1, 4'hF, 32'h100, 32'h11223344);
      chk("st1_ready", 32'(ready), 1);
      chk("st1_en", 32'(en), 0);
      set_in(0, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D);
      chk("st1_drain_en", 32'(en), 1);
      chk("st1_drain_wen", 32'(wen), 32'hF);
      chk("st1_drain_addr", s_addr, 32'h100);
      chk("st1_drain_wdata", s_wdata, 32'h11223344);
      set_in(0, 0, 0, 0, 0);
      chk("st1_count_after", 32'(count), 0);
      chk("st1_idle_en", 32'(en), 0);

      // Load hitting a pending store waits for the drain.
      set_in(1, 1, 4'hF, 32'h200, 32'hAABBCCDD);
      chk("hit_st_ready", 32'(ready), 1);
      set_in(1, 0, 0, 32'h202, 0);
      chk("hit_ld_stall", 32'(ready), 0);
      chk("hit_drain_wen", 32'(wen), 32'hF);
      chk("hit_drain_addr", s_addr, 32'h200);
      set_in(1, 0, 0, 32'h202, 0);
      chk("hit_ld_go", 32'(ready), 1);
      chk("hit_ld_wen", 32'(wen), 0);
      chk("hit_ld_addr", s_addr, 32'h202);

      // Load streak: eight loads overtake, ninth yields one cycle to the head.
      set_in(1, 1, 4'h3, 32'h200, 32'h55667788);
      chk("strk_st_ready", 32'(ready), 1);
      for (int i = 0; i < MAX; i++) begin
         set_in(1, 0, 0, 32'h300, 0);
         chk("strk_ld_ready", 32'(ready), 1);
         chk("strk_ld_wen", 32'(wen), 0);
         chk("strk_count", 32'(count), 1);
      end
      set_in(1, 0, 0, 32'h300, 0);
      chk("strk_forced_ready", 32'(ready), 0);
      chk("strk_forced_wen", 32'(wen), 32'h3);
      chk("strk_forced_addr", s_addr, 32'h200);
      set_in(1, 0, 0, 32'h300, 0);
      chk("strk_resume_ready", 32'(ready), 1);
      chk("strk_resume_count", 32'(count), 0);

      // Zero-strobe store is acknowledged but never written.
      set_in(1, 1, 4'h0, 32'h500, 32'h12345678);
      chk("zs_ready", 32'(ready), 1);
      set_in(0, 0, 0, 0, 0);
      chk("zs_no_write", 32'(en), 0);

      // Reset with a store queued discards it.
      set_in(1, 1, 4'hF, 32'h400, 32'h99999999);
      @(posedge clk); #1; rst = 1; valid = 1; wr = 0; addr = 32'h400;
      @(negedge clk);
      chk("rstq_ready", 32'(ready), 0);
      chk("rstq_en", 32'(en), 0);
      chk("rstq_wen", 32'(wen), 0);
      set_in(0, 0, 0, 0, 0);
      rst = 0;
      #1;
      chk("rstq_empty", 32'(empty), 1);
      chk("rstq_after_en", 32'(en), 0);

      // Randomized traffic over a small address window to provoke hits.
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         rst   = ($urandom_range(0, 199) == 0);
         valid = ($urandom_range(0, 9) < 7);
         wr    = ($urandom_range(0, 9) < 4);
         wstrb = 4'($urandom_range(0, 15));
         addr  = 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
         wdata = $urandom;
      end
      @(posedge clk); #1;
      rst = 0; valid = 0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
